oled_framebuffer: RTL and testbench

Camera-to-OLED frame buffer, directly upstream of the SSD1351 SPI scan core. Accepts a raster camera pixel stream and crops and decimates it to 128x128 by integer steps. Stores the result in block RAM, single- or double-buffered, and returns `color` for the scan core's `x`/`y` requests. Double-buffer mode swaps banks only at a display frame boundary, so the OLED never shows a torn frame.

---
 rtl/oled_fb_pkg.sv | 31 +++
 rtl/fb_dpram.sv | 33 +++
 rtl/oled_framebuffer.sv | 209 ++++++++++++++++++++
 tb/tb_oled_framebuffer.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/oled_fb_pkg.sv
// Shared constants and types for the camera-to-OLED frame buffer.
package oled_fb_pkg;

   // Default display geometry and derived widths
   localparam int unsigned c_def_x_size     = 128;
   localparam int unsigned c_def_y_size     = 128;
   localparam int unsigned c_def_x_bits     = $clog2(c_def_x_size);
   localparam int unsigned c_def_y_bits     = $clog2(c_def_y_size);
   localparam int unsigned c_def_color_bits = 16;

   // Default source geometry and crop window
   localparam int unsigned c_def_src_x_size = 640;
   localparam int unsigned c_def_src_y_size = 480;
   localparam int unsigned c_def_x_off      = 128;
   localparam int unsigned c_def_y_off      = 48;
   localparam int unsigned c_def_step       = 3;

   // Writer states
   typedef enum logic [1:0] {
      StIdle,
      StWrite,
      StSkip
   } wr_state_e;

   // Exclusive end of the crop window along one axis
   function automatic int unsigned win_end(input int unsigned off, input int unsigned step,
                                           input int unsigned size);
      return off + step * size;
   endfunction

endpackage

// File: rtl/fb_dpram.sv
// Simple dual-port RAM: one write port, one registered read port, single clock.
module fb_dpram #(
   parameter int unsigned c_addr_bits = 15,
   parameter int unsigned c_data_bits = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   we,
   input  logic [c_addr_bits-1:0] waddr,
   input  logic [c_data_bits-1:0] wdata,
   input  logic [c_addr_bits-1:0] raddr,
   output logic [c_data_bits-1:0] rdata
);

   logic [c_data_bits-1:0] mem [1 << c_addr_bits];

   // Write port; contents are never reset
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   // Registered read port; read-before-write on an address collision
   always_ff @(posedge clk) begin
      if (reset) begin
         rdata <= '0;
      end else begin
         rdata <= mem[raddr];
      end
   end

endmodule

// File: rtl/oled_framebuffer.sv
// Crops and decimates a raster camera stream to the display size, stores it in
// block RAM (one or two banks) and serves pixels to the OLED scan core.
module oled_framebuffer
   import oled_fb_pkg::*;
#(
   parameter int unsigned c_x_size     = c_def_x_size,
   parameter int unsigned c_y_size     = c_def_y_size,
   parameter int unsigned c_color_bits = c_def_color_bits,
   parameter int unsigned c_src_x_size = c_def_src_x_size,
   parameter int unsigned c_src_y_size = c_def_src_y_size,
   parameter int unsigned c_x_off      = c_def_x_off,
   parameter int unsigned c_y_off      = c_def_y_off,
   parameter int unsigned c_step       = c_def_step,
   parameter int unsigned c_double_buf = 1
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        pix_valid,
   input  logic                        pix_sof,
   input  logic                        pix_eol,
   input  logic [c_color_bits-1:0]     pix_data,
   input  logic [$clog2(c_x_size)-1:0] x,
   input  logic [$clog2(c_y_size)-1:0] y,
   input  logic                        next_pixel,
   output logic [c_color_bits-1:0]     color,
   output logic                        disp_bank,
   output logic                        frame_done,
   output logic                        frame_drop
);

   localparam int unsigned x_bits  = $clog2(c_x_size);
   localparam int unsigned y_bits  = $clog2(c_y_size);
   localparam int unsigned sx_bits = $clog2(c_src_x_size + 1);
   localparam int unsigned sy_bits = $clog2(c_src_y_size + 1);
   localparam int unsigned ph_bits = (c_step > 1) ? $clog2(c_step) : 1;
   localparam int unsigned aw      = x_bits + y_bits + ((c_double_buf != 0) ? 1 : 0);

   localparam logic [sx_bits-1:0] x_lo    = sx_bits'(c_x_off);
   localparam logic [sx_bits-1:0] x_hi    = sx_bits'(win_end(c_x_off, c_step, c_x_size));
   localparam logic [sy_bits-1:0] y_lo    = sy_bits'(c_y_off);
   localparam logic [sy_bits-1:0] y_hi    = sy_bits'(win_end(c_y_off, c_step, c_y_size));
   localparam logic [sx_bits-1:0] sx_max  = sx_bits'(c_src_x_size - 1);
   localparam logic [sy_bits-1:0] sy_max  = sy_bits'(c_src_y_size - 1);
   localparam logic [ph_bits-1:0] ph_last = ph_bits'(c_step - 1);
   localparam logic [x_bits-1:0]  x_last  = x_bits'(c_x_size - 1);
   localparam logic [y_bits-1:0]  y_last  = y_bits'(c_y_size - 1);

   wr_state_e state_q, state_d, beat_state;

   logic [sx_bits-1:0]      src_x_q, src_x_d, cx;
   logic [sy_bits-1:0]      src_y_q, src_y_d, cy;
   logic [ph_bits-1:0]      ph_x_q, ph_x_d, cphx;
   logic [ph_bits-1:0]      ph_y_q, ph_y_d, cphy;
   logic [x_bits-1:0]       wr_x_q, wr_x_d, cwx;
   logic [y_bits-1:0]       wr_y_q, wr_y_d, cwy;
   logic                    wr_bank_q, wr_bank_d;
   logic                    pending_q, pending_d, set_pending;
   logic                    disp_bank_q, disp_bank_d, swap;
   logic                    done_q, done_d, drop_q, drop_d;
   logic                    we_q, we_d;
   logic [aw-1:0]           waddr_q, waddr_d, raddr;
   logic [c_color_bits-1:0] wdata_q, wdata_d;
   logic                    sof_beat, in_x, in_y, hit;
   logic [x_bits+y_bits:0]  full_waddr, full_raddr;

   // Writer: source counters, decimation phases, write address and state
   always_comb begin
      state_d     = state_q;
      src_x_d     = src_x_q;
      src_y_d     = src_y_q;
      ph_x_d      = ph_x_q;
      ph_y_d      = ph_y_q;
      wr_x_d      = wr_x_q;
      wr_y_d      = wr_y_q;
      wr_bank_d   = wr_bank_q;
      we_d        = 1'b0;
      waddr_d     = waddr_q;
      wdata_d     = wdata_q;
      done_d      = 1'b0;
      drop_d      = 1'b0;
      set_pending = 1'b0;

      sof_beat = pix_valid & pix_sof;

      // A sof beat is handled as source pixel (0,0) of a fresh frame
      cx   = sof_beat ? '0 : src_x_q;
      cy   = sof_beat ? '0 : src_y_q;
      cphx = sof_beat ? '0 : ph_x_q;
      cphy = sof_beat ? '0 : ph_y_q;
      cwx  = sof_beat ? '0 : wr_x_q;
      cwy  = sof_beat ? '0 : wr_y_q;

      if (sof_beat) begin
         if ((c_double_buf != 0) && pending_q) begin
            state_d = StSkip;
            drop_d  = 1'b1;
         end else begin
            state_d   = StWrite;
            wr_bank_d = (c_double_buf != 0) ? ~disp_bank_q : 1'b0;
         end
      end
      beat_state = state_d;

      in_x = (cx >= x_lo) && (cx < x_hi);
      in_y = (cy >= y_lo) && (cy < y_hi);
      hit  = pix_valid && (beat_state == StWrite) && in_x && in_y &&
             (cphx == '0) && (cphy == '0);

      full_waddr = {wr_bank_d, cwy, cwx};
      wr_x_d     = cwx;
      wr_y_d     = cwy;
      if (hit) begin
         we_d    = 1'b1;
         waddr_d = full_waddr[aw-1:0];
         wdata_d = pix_data;
         wr_x_d  = cwx + x_bits'(1);
         if (cwx == x_last) begin
            wr_y_d = cwy + y_bits'(1);
            if (cwy == y_last) begin
               done_d      = 1'b1;
               set_pending = 1'b1;
               state_d     = StIdle;
            end
         end
      end

      // Counters only track beats of a frame that has seen its sof
      if (pix_valid && (sof_beat || (state_q != StIdle))) begin
         ph_x_d = in_x ? ((cphx == ph_last) ? '0 : cphx + ph_bits'(1)) : cphx;
         ph_y_d = cphy;
         if (pix_eol) begin
            src_x_d = '0;
            ph_x_d  = '0;
            src_y_d = (cy == sy_max) ? cy : cy + sy_bits'(1);
            if (in_y) begin
               ph_y_d = (cphy == ph_last) ? '0 : cphy + ph_bits'(1);
            end
         end else begin
            src_x_d = (cx == sx_max) ? cx : cx + sx_bits'(1);
            src_y_d = cy;
         end
      end
   end

   // Read side: bank swap at display (0,0) and read address
   always_comb begin
      swap        = (c_double_buf != 0) && next_pixel && (x == '0) && (y == '0) && pending_q;
      disp_bank_d = disp_bank_q ^ swap;
      // Swap uses the old pending, so a frame finishing this cycle waits a display frame
      pending_d   = (pending_q & ~swap) | set_pending;
      full_raddr  = {disp_bank_d, y, x};
      raddr       = full_raddr[aw-1:0];
   end

   // State and pipeline registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= StIdle;
         src_x_q     <= '0;
         src_y_q     <= '0;
         ph_x_q      <= '0;
         ph_y_q      <= '0;
         wr_x_q      <= '0;
         wr_y_q      <= '0;
         wr_bank_q   <= 1'b0;
         pending_q   <= 1'b0;
         disp_bank_q <= 1'b0;
         done_q      <= 1'b0;
         drop_q      <= 1'b0;
         we_q        <= 1'b0;
         waddr_q     <= '0;
         wdata_q     <= '0;
      end else begin
         state_q     <= state_d;
         src_x_q     <= src_x_d;
         src_y_q     <= src_y_d;
         ph_x_q      <= ph_x_d;
         ph_y_q      <= ph_y_d;
         wr_x_q      <= wr_x_d;
         wr_y_q      <= wr_y_d;
         wr_bank_q   <= wr_bank_d;
         pending_q   <= pending_d;
         disp_bank_q <= disp_bank_d;
         done_q      <= done_d;
         drop_q      <= drop_d;
         we_q        <= we_d;
         waddr_q     <= waddr_d;
         wdata_q     <= wdata_d;
      end
   end

   assign disp_bank  = disp_bank_q;
   assign frame_done = done_q;
   assign frame_drop = drop_q;

   fb_dpram #(
      .c_addr_bits(aw),
      .c_data_bits(c_color_bits)
   ) u_ram (
      .clk  (clk),
      .reset(reset),
      .we   (we_q),
      .waddr(waddr_q),
      .wdata(wdata_q),
      .raddr(raddr),
      .rdata(color)
   );

endmodule

// File: tb/tb_oled_framebuffer.sv
// Directed bench for oled_framebuffer on a reduced geometry (8x8 display,
// 40x32 source, window at (4,2), step 3); one double- and one single-buffer instance.
module tb_oled_framebuffer;

   localparam int XS = 8, YS = 8, SXS = 40, SYS = 32, XOFF = 4, YOFF = 2, STEP = 3;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        pix_valid = 1'b0, pix_sof = 1'b0, pix_eol = 1'b0;
   logic [15:0] pix_data = '0;
   logic [2:0]  x = '0, y = '0;
   logic        next_pixel = 1'b0;
   logic [15:0] color_db, color_sb;
   logic        bank_db, bank_sb, done_db, done_sb, drop_db, drop_sb;

   always #5 clk = ~clk;

   oled_framebuffer #(
      .c_x_size(XS), .c_y_size(YS), .c_color_bits(16), .c_src_x_size(SXS),
      .c_src_y_size(SYS), .c_x_off(XOFF), .c_y_off(YOFF), .c_step(STEP), .c_double_buf(1)
   ) dut_db (
      .clk(clk), .reset(reset), .pix_valid(pix_valid), .pix_sof(pix_sof), .pix_eol(pix_eol),
      .pix_data(pix_data), .x(x), .y(y), .next_pixel(next_pixel), .color(color_db),
      .disp_bank(bank_db), .frame_done(done_db), .frame_drop(drop_db)
   );

   oled_framebuffer #(
      .c_x_size(XS), .c_y_size(YS), .c_color_bits(16), .c_src_x_size(SXS),
      .c_src_y_size(SYS), .c_x_off(XOFF), .c_y_off(YOFF), .c_step(STEP), .c_double_buf(0)
   ) dut_sb (
      .clk(clk), .reset(reset), .pix_valid(pix_valid), .pix_sof(pix_sof), .pix_eol(pix_eol),
      .pix_data(pix_data), .x(x), .y(y), .next_pixel(next_pixel), .color(color_sb),
      .disp_bank(bank_sb), .frame_done(done_sb), .frame_drop(drop_sb)
   );

   int n_vec = 0, n_bad = 0;
   int n_done_db = 0, n_done_sb = 0, n_drop_db = 0, n_drop_sb = 0;

   // Pulse counters
   always @(negedge clk) begin
      if (done_db) n_done_db++;
      if (done_sb) n_done_sb++;
      if (drop_db) n_drop_db++;
      if (drop_sb) n_drop_sb++;
   end

   typedef struct {
      int          rx;
      int          ry;
      logic [15:0] exp0;  // pattern {sy,sx}
      logic [15:0] exp1;  // pattern {sy,sx} ^ 16'h5A5A
   } vec_t;
   vec_t tbl[6];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [15:0] pdata(input int mode, input int sx, input int sy);
      logic [15:0] v;
      v = 16'(((sy & 255) << 8) | (sx & 255));
      if (mode == 1) v = v ^ 16'h5A5A;
      if (mode == 2) v = 16'hF800;
      return v;
   endfunction

   // Source lines first..last; line long_line is long_len beats with eol on its last beat
   task automatic send_lines(input int mode, input int first, input int last, input bit with_sof,
                             input int long_line, input int long_len);
      for (int ly = first; ly <= last; ly++) begin
         int len = (ly == long_line) ? long_len : SXS;
         for (int i = 0; i < len; i++) begin
            int sx = (i > SXS - 1) ? SXS - 1 : i;
            pix_valid = 1'b1;
            pix_sof   = with_sof && (ly == first) && (i == 0);
            pix_eol   = (i == len - 1);
            pix_data  = pdata(mode, sx, ly);
            @(negedge clk);
         end
      end
      pix_valid = 1'b0;
      pix_sof   = 1'b0;
      pix_eol   = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic read_px(input int rx, input int ry);
      x          = 3'(rx);
      y          = 3'(ry);
      next_pixel = 1'b1;
      @(negedge clk);
      next_pixel = 1'b0;
      @(negedge clk);
   endtask

   task automatic check_image(input string tag, input int mode, input logic exp_bank);
      for (int i = 0; i < 6; i++) begin
         read_px(tbl[i].rx, tbl[i].ry);
         check($sformatf("%s color(%0d,%0d)", tag, tbl[i].rx, tbl[i].ry), 32'(color_db),
               32'((mode == 1) ? tbl[i].exp1 : tbl[i].exp0));
      end
      check({tag, " disp_bank"}, 32'(bank_db), 32'(exp_bank));
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int d_done, d_drop;
      // display (x,y) <- source (4+3x, 2+3y)
      tbl[0] = '{0, 0, 16'h0204, 16'h585E};
      tbl[1] = '{1, 0, 16'h0207, 16'h585D};
      tbl[2] = '{7, 0, 16'h0219, 16'h5843};
      tbl[3] = '{3, 5, 16'h110D, 16'h4B57};
      tbl[4] = '{0, 7, 16'h1704, 16'h4D5E};
      tbl[5] = '{7, 7, 16'h1719, 16'h4D43};

      repeat (3) @(negedge clk);
      check("reset color", 32'(color_db), 32'h0);
      check("reset disp_bank", 32'(bank_db), 32'h0);
      check("reset frame_done", 32'(done_db), 32'h0);
      check("reset frame_drop", 32'(drop_db), 32'h0);
      reset = 1'b0;
      @(negedge clk);

      // Frame A lands in bank 1, shown after the next display (0,0)
      d_done = n_done_db; d_drop = n_drop_db;
      send_lines(0, 0, SYS - 1, 1'b1, -1, 0);
      check("A frame_done count", 32'(n_done_db - d_done), 32'd1);
      check("A frame_drop count", 32'(n_drop_db - d_drop), 32'd0);
      check("A no early swap", 32'(bank_db), 32'd0);
      check_image("A", 0, 1'b1);

      // Frame B completes into bank 0; frame C arrives while B is pending and is dropped
      d_done = n_done_db;
      send_lines(1, 0, SYS - 1, 1'b1, -1, 0);
      check("B frame_done count", 32'(n_done_db - d_done), 32'd1);
      d_done = n_done_db; d_drop = n_drop_db;
      send_lines(0, 0, SYS - 1, 1'b1, -1, 0);
      check("C frame_drop count", 32'(n_drop_db - d_drop), 32'd1);
      check("C frame_done count", 32'(n_done_db - d_done), 32'd0);
      read_px(3, 5);
      check("C bank held", 32'(bank_db), 32'd1);
      check("C still A data", 32'(color_db), 32'h110D);
      check_image("B", 1, 1'b0);

      // Aborted frame: sof repeated after 10 lines
      d_done = n_done_db; d_drop = n_drop_db;
      send_lines(0, 0, 9, 1'b1, -1, 0);
      check("abort frame_done count", 32'(n_done_db - d_done), 32'd0);
      read_px(0, 0);
      check("abort no swap", 32'(bank_db), 32'd0);
      send_lines(1, 0, SYS - 1, 1'b1, -1, 0);
      check("E frame_done count", 32'(n_done_db - d_done), 32'd1);
      check("E frame_drop count", 32'(n_drop_db - d_drop), 32'd0);
      check_image("E", 1, 1'b1);

      // Reset in the middle of a written frame
      send_lines(0, 0, 9, 1'b1, -1, 0);
      reset = 1'b1;
      @(negedge clk);
      check("midreset color", 32'(color_db), 32'h0);
      check("midreset disp_bank", 32'(bank_db), 32'h0);
      reset = 1'b0;
      d_done = n_done_db;
      send_lines(0, 10, SYS - 1, 1'b0, -1, 0);
      check("midreset beats ignored", 32'(n_done_db - d_done), 32'd0);
      read_px(0, 0);
      check("midreset no swap", 32'(bank_db), 32'd0);
      send_lines(0, 0, SYS - 1, 1'b1, -1, 0);
      check("G frame_done count", 32'(n_done_db - d_done), 32'd1);
      check_image("G", 0, 1'b1);

      // Over-long first window line with saturating src_x
      d_done = n_done_db;
      send_lines(1, 0, SYS - 1, 1'b1, YOFF, 80);
      check("H frame_done count", 32'(n_done_db - d_done), 32'd1);
      check_image("H", 1, 1'b0);

      // Single-buffer instance: full 0xF800 frame
      d_done = n_done_sb;
      send_lines(2, 0, SYS - 1, 1'b1, -1, 0);
      check("SB frame_done count", 32'(n_done_sb - d_done), 32'd1);
      for (int py = 0; py < YS; py++) begin
         for (int px = 0; px < XS; px++) begin
            read_px(px, py);
            check($sformatf("SB color(%0d,%0d)", px, py), 32'(color_sb), 32'hF800);
         end
      end
      check("SB disp_bank", 32'(bank_sb), 32'd0);
      check("SB frame_drop never", 32'(n_drop_sb), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
